ofdm_frame_counter: RTL and testbench

Two-level parametrised timing counter for the OFDM baseband transmitter. It counts samples within a symbol (FFT length plus cyclic prefix) and symbols within a frame. Both terminal values are loadable at run time, and the block supports either saturating (one-shot) or auto-wrapping operation. It drives the symbol/frame timing strobes for the IFFT, CP-insertion and framing stages.

---
 rtl/ofdm_cnt_pkg.sv | 13 +
 rtl/ofdm_frame_counter_limit_counter.sv | 37 +++
 rtl/ofdm_frame_counter.sv | 95 +++++++++
 tb/tb_ofdm_frame_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ofdm_cnt_pkg.sv
// rtl/ofdm_cnt_pkg.sv - shared states and mode constants for the OFDM frame counter
package ofdm_cnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

endpackage

// File: rtl/ofdm_frame_counter_limit_counter.sv
// rtl/ofdm_frame_counter_limit_counter.sv - loadable-limit counter that wraps to zero at its terminal value
module limit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc  = (cnt_q == limit);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tc ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ofdm_frame_counter.sv
// rtl/ofdm_frame_counter.sv - two-level sample/symbol timing counter with frame strobe
module ofdm_frame_counter
    import ofdm_cnt_pkg::*;
#(
    parameter int                    SAMPLE_W         = 7,
    parameter int                    SYMBOL_W         = 4,
    parameter logic [SAMPLE_W-1:0]   SAMPLE_LIMIT_DEF = 79,
    parameter logic [SYMBOL_W-1:0]   SYMBOL_LIMIT_DEF = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [SAMPLE_W-1:0] sample_limit_i,
    input  logic [SYMBOL_W-1:0] symbol_limit_i,
    input  logic                mode_i,
    output logic [SAMPLE_W-1:0] sample_cnt,
    output logic [SYMBOL_W-1:0] symbol_cnt,
    output logic                sample_tc,
    output logic                symbol_tc,
    output logic                frame_done,
    output logic                busy
);

    state_e              state_q;
    state_e              state_d;
    logic [SAMPLE_W-1:0] sample_lim_q;
    logic [SYMBOL_W-1:0] symbol_lim_q;
    logic                mode_q;
    logic                frame_done_q;
    logic                frame_done_d;
    logic                frame_tc;
    logic                active;
    logic                step;
    logic                clr;

    assign frame_tc = sample_tc & symbol_tc;
    // IDLE with en behaves as the first RUN step, so zero limits strobe on the first edge.
    assign active   = en & ~load & ((state_q == ST_IDLE) | (state_q == ST_RUN));
    assign step     = active & ~(frame_tc & (mode_q == MODE_SAT));
    assign clr      = load | ~en;

    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        if (load || !en) begin
            state_d = ST_IDLE;
        end else if (active) begin
            frame_done_d = frame_tc;
            state_d      = (frame_tc && mode_q == MODE_SAT) ? ST_DONE : ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_done_q <= 1'b0;
            sample_lim_q <= SAMPLE_LIMIT_DEF;
            symbol_lim_q <= SYMBOL_LIMIT_DEF;
            mode_q       <= MODE_SAT;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            if (load) begin
                sample_lim_q <= sample_limit_i;
                symbol_lim_q <= symbol_limit_i;
                mode_q       <= mode_i;
            end
        end
    end

    limit_counter #(.W(SAMPLE_W)) u_sample_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (step),
        .clr   (clr),
        .limit (sample_lim_q),
        .cnt   (sample_cnt),
        .tc    (sample_tc)
    );

    limit_counter #(.W(SYMBOL_W)) u_symbol_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (step & sample_tc),
        .clr   (clr),
        .limit (symbol_lim_q),
        .cnt   (symbol_cnt),
        .tc    (symbol_tc)
    );

    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_ofdm_frame_counter.sv
// tb/tb_ofdm_frame_counter.sv - directed self-checking bench for ofdm_frame_counter
module tb_ofdm_frame_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [6:0] sample_limit_i;
    logic [3:0] symbol_limit_i;
    logic       mode_i;
    logic [6:0] sample_cnt;
    logic [3:0] symbol_cnt;
    logic       sample_tc;
    logic       symbol_tc;
    logic       frame_done;
    logic       busy;

    int errors;
    int checks;
    int pulses;

    ofdm_frame_counter dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .load           (load),
        .sample_limit_i (sample_limit_i),
        .symbol_limit_i (symbol_limit_i),
        .mode_i         (mode_i),
        .sample_cnt     (sample_cnt),
        .symbol_cnt     (symbol_cnt),
        .sample_tc      (sample_tc),
        .symbol_tc      (symbol_tc),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int slim, input int ylim, input logic mode);
        load           = 1'b1;
        en             = 1'b1;
        sample_limit_i = 7'(slim);
        symbol_limit_i = 4'(ylim);
        mode_i         = mode;
        tick();
        load = 1'b0;
    endtask

    task automatic run_default_frame(input string tag);
        pulses = 0;
        for (int i = 0; i < 805; i++) begin
            tick();
            if (i == 79) begin
                chk({tag, "_sym_step_s"}, 32'(sample_cnt), 0);
                chk({tag, "_sym_step_y"}, 32'(symbol_cnt), 1);
            end
            if (frame_done) pulses = pulses + 1;
        end
        chk({tag, "_sample"}, 32'(sample_cnt), 79);
        chk({tag, "_symbol"}, 32'(symbol_cnt), 9);
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fd_low"}, 32'(frame_done), 0);
        chk({tag, "_tc"}, 32'({sample_tc, symbol_tc}), 3);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        en             = 1'b0;
        load           = 1'b0;
        sample_limit_i = '0;
        symbol_limit_i = '0;
        mode_i         = 1'b0;
        #12;
        chk("rst_sample", 32'(sample_cnt), 0);
        chk("rst_symbol", 32'(symbol_cnt), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_tc", 32'({sample_tc, symbol_tc}), 0);

        // Default limits, SAT: one frame of 800 enabled cycles then hold.
        rst = 1'b0;
        en  = 1'b1;
        tick();
        chk("sat_first_busy", 32'(busy), 1);
        chk("sat_first_cnt", 32'(sample_cnt), 1);
        en = 1'b0;
        tick();
        en = 1'b1;
        run_default_frame("sat_def");

        // WRAP 3/2: 12-cycle frame.
        do_load(3, 2, 1'b1);
        chk("wrap_load_cnt", 32'({symbol_cnt, sample_cnt}), 0);
        chk("wrap_load_busy", 32'(busy), 0);
        for (int k = 1; k <= 26; k++) begin
            tick();
            chk($sformatf("wrap_s%0d", k), 32'(sample_cnt), k % 4);
            chk($sformatf("wrap_y%0d", k), 32'(symbol_cnt), (k / 4) % 3);
            chk($sformatf("wrap_fd%0d", k), 32'(frame_done), (k % 12 == 0) ? 1 : 0);
        end

        // SAT 3/2: en drop mid-frame clears counts, restart from zero.
        do_load(3, 2, 1'b0);
        for (int k = 0; k < 6; k++) tick();
        chk("drop_pre_s", 32'(sample_cnt), 2);
        chk("drop_pre_y", 32'(symbol_cnt), 1);
        en = 1'b0;
        tick();
        chk("drop_cnt", 32'({symbol_cnt, sample_cnt}), 0);
        chk("drop_busy", 32'(busy), 0);
        en     = 1'b1;
        pulses = 0;
        for (int k = 0; k < 11; k++) begin
            tick();
            if (frame_done) pulses = pulses + 1;
        end
        chk("drop_no_early_fd", pulses, 0);
        tick();
        chk("drop_fd12", 32'(frame_done), 1);

        // load with en high mid-frame: load wins, new 1/1 limits give a 4-cycle frame.
        do_load(3, 2, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        chk("ld_pre_s", 32'(sample_cnt), 2);
        chk("ld_pre_y", 32'(symbol_cnt), 1);
        do_load(1, 1, 1'b0);
        chk("ld_cnt", 32'({symbol_cnt, sample_cnt}), 0);
        chk("ld_busy", 32'(busy), 0);
        chk("ld_fd", 32'(frame_done), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("ld_fd%0d", k), 32'(frame_done), 0);
        end
        tick();
        chk("ld_fd4", 32'(frame_done), 1);
        tick();
        chk("ld_done_fd", 32'(frame_done), 0);
        chk("ld_done_busy", 32'(busy), 0);
        chk("ld_done_s", 32'(sample_cnt), 1);
        chk("ld_done_y", 32'(symbol_cnt), 1);

        // Zero limits in WRAP: strobe on every enabled edge.
        do_load(0, 0, 1'b1);
        chk("z_tc_idle", 32'({sample_tc, symbol_tc}), 3);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("z_fd%0d", k), 32'(frame_done), 1);
            chk($sformatf("z_tc%0d", k), 32'({sample_tc, symbol_tc}), 3);
            chk($sformatf("z_cnt%0d", k), 32'({symbol_cnt, sample_cnt}), 0);
        end

        // Asynchronous reset mid-RUN restores defaults.
        do_load(3, 2, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        chk("ar_pre_s", 32'(sample_cnt), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_cnt", 32'({symbol_cnt, sample_cnt}), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_fd", 32'(frame_done), 0);
        chk("ar_tc", 32'({sample_tc, symbol_tc}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        run_default_frame("ar_def");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
